// File: rtl/noc_pkg.sv
// Shared definitions for the PE network interface.
// Holds the packet address-field helpers and the TX/RX FSM state encodings.
// A packet is {src_x, src_y, payload}, with the address field in the MSBs.
package noc_pkg;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_SEND = 2'd1,
        TX_GAP  = 2'd2
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_POP  = 2'd1,
        RX_GAP  = 2'd2
    } rx_state_e;

    // Width of the {x,y} address field for an XNO x YNO mesh.
    function automatic int unsigned addr_width(input int unsigned xno, input int unsigned yno);
        return $clog2(xno) + $clog2(yno);
    endfunction

    // Bit position of the address field LSB within a packet.
    function automatic int unsigned addr_lsb(input int unsigned packet_size, input int unsigned aw);
        return packet_size - aw;
    endfunction

endpackage

// File: rtl/pe_net_iface_if.sv
// Switch-side PE port bundle between pe_net_iface and its mesh switch.
//   pkt_out  : NI -> switch i_data_PE
//   wr_valid : NI -> switch i_wr_valid_PE (one-cycle write strobe)
//   wr_ready : switch o_wr_fifoReady_PE -> NI (PE input FIFO not full)
//   pkt_in   : switch o_data_PE -> NI (first-word fall-through)
//   rd_valid : switch o_rd_valid_PE -> NI (PE output FIFO not empty)
//   rd_en    : NI -> switch i_rd_fifoReady_PE (one-cycle pop)
// master = network interface side, slave = switch side.
interface pe_net_iface_if #(
    parameter int unsigned PACKET_SIZE = 16
);
    logic [PACKET_SIZE-1:0] pkt_out;
    logic                   wr_valid;
    logic                   wr_ready;
    logic [PACKET_SIZE-1:0] pkt_in;
    logic                   rd_valid;
    logic                   rd_en;

    modport master (
        output pkt_out,
        output wr_valid,
        input  wr_ready,
        input  pkt_in,
        input  rd_valid,
        output rd_en
    );

    modport slave (
        input  pkt_out,
        input  wr_valid,
        output wr_ready,
        output pkt_in,
        output rd_valid,
        input  rd_en
    );
endinterface

// File: rtl/pe_vec_collect.sv
// Input-vector collector: per-source slot storage, arrival bitmap,
// completion detect and sticky error flags.
// Ports:
//   clk, i_reset     : clock, synchronous active-high reset
//   i_wr, i_src,
//   i_payload        : one decoded packet to file (single-cycle strobe)
//   i_expect_mask    : sources required for a complete vector
//   i_vec_ack        : consumer took the vector
//   o_vec_valid      : full vector present (registered)
//   o_vec_data       : slot i at [i*DW +: DW]
//   o_err_dup        : sticky, a source arrived twice in one vector
//   o_err_unexp      : sticky, packet from a source outside the mask
module pe_vec_collect #(
    parameter int unsigned N  = 16,
    parameter int unsigned DW = 12,
    parameter int unsigned AW = 4
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_wr,
    input  logic [AW-1:0]   i_src,
    input  logic [DW-1:0]   i_payload,
    input  logic [N-1:0]    i_expect_mask,
    input  logic            i_vec_ack,
    output logic            o_vec_valid,
    output logic [N*DW-1:0] o_vec_data,
    output logic            o_err_dup,
    output logic            o_err_unexp
);

    logic [N-1:0]          bitmap;
    logic [N-1:0][DW-1:0]  slots;
    logic                  in_mask_c;
    logic                  seen_c;
    logic                  full_c;

    assign in_mask_c  = i_expect_mask[i_src];
    assign seen_c     = bitmap[i_src];
    assign full_c     = (i_expect_mask != '0) && ((bitmap & i_expect_mask) == i_expect_mask);
    assign o_vec_data = slots;

    // Ack clears arrivals only; slot contents survive for the next vector.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            bitmap      <= '0;
            slots       <= '0;
            o_vec_valid <= 1'b0;
            o_err_dup   <= 1'b0;
            o_err_unexp <= 1'b0;
        end else if (i_vec_ack && o_vec_valid) begin
            bitmap      <= '0;
            o_vec_valid <= 1'b0;
        end else begin
            o_vec_valid <= full_c;
            if (i_wr) begin
                if (!in_mask_c) begin
                    o_err_unexp <= 1'b1;
                end else begin
                    slots[i_src]  <= i_payload;
                    bitmap[i_src] <= 1'b1;
                    if (seen_c) begin
                        o_err_dup <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/pe_net_iface.sv
// Network interface between a neuron PE and the PE port of its mesh switch.
// TX: accepts one result, packs {X, Y, payload}, writes it to the switch.
// RX: pops packets from the switch and files payloads by source address;
//     presents the full input vector once every expected source arrived.
// Ports:
//   clk, i_reset                  : clock, synchronous active-high reset
//   i_tx_valid, i_tx_data,
//   o_tx_ready                    : PE result handshake
//   sw                            : switch PE port (pe_net_iface_if.master)
//   i_expect_mask                 : sources required per vector
//   o_vec_valid, o_vec_data,
//   i_vec_ack                     : vector handoff to the PE
//   o_err_dup, o_err_unexp        : sticky error flags
//   o_tx_count, o_rx_count        : packet counters, only with PE_NI_STATS_EN
module pe_net_iface
    import noc_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = 16,
    parameter int unsigned XNO         = 4,
    parameter int unsigned YNO         = 4,
    parameter int unsigned X           = 0,
    parameter int unsigned Y           = 0,
    localparam int unsigned XW         = $clog2(XNO),
    localparam int unsigned YW         = $clog2(YNO),
    localparam int unsigned AW         = addr_width(XNO, YNO),
    localparam int unsigned DW         = PACKET_SIZE - AW,
    localparam int unsigned N          = XNO * YNO
) (
    input  logic            clk,
    input  logic            i_reset,
    input  logic            i_tx_valid,
    input  logic [DW-1:0]   i_tx_data,
    output logic            o_tx_ready,
    pe_net_iface_if.master  sw,
    input  logic [N-1:0]    i_expect_mask,
    output logic            o_vec_valid,
    output logic [N*DW-1:0] o_vec_data,
    input  logic            i_vec_ack,
    output logic            o_err_dup,
`ifdef PE_NI_STATS_EN
    output logic            o_err_unexp,
    output logic [15:0]     o_tx_count,
    output logic [15:0]     o_rx_count
`else
    output logic            o_err_unexp
`endif
);

    localparam int unsigned ADDR_LSB = addr_lsb(PACKET_SIZE, AW);

    // ---------------- TX path ----------------
    tx_state_e tx_state;
    tx_state_e tx_state_nxt;
    logic      tx_accept_c;
    logic      tx_strobe_c;

    always_ff @(posedge clk) begin
        if (i_reset) tx_state <= TX_IDLE;
        else         tx_state <= tx_state_nxt;
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_accept_c  = 1'b0;
        tx_strobe_c  = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                if (o_tx_ready && i_tx_valid) begin
                    tx_accept_c  = 1'b1;
                    tx_state_nxt = TX_SEND;
                end
            end
            TX_SEND: begin
                if (sw.wr_ready) begin
                    tx_strobe_c  = 1'b1;
                    tx_state_nxt = TX_GAP;
                end
            end
            TX_GAP:  tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Ready is registered from the next state, so it is low during reset and
    // high exactly while the FSM sits in TX_IDLE.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            sw.pkt_out  <= '0;
            sw.wr_valid <= 1'b0;
            o_tx_ready  <= 1'b0;
        end else begin
            sw.wr_valid <= tx_strobe_c;
            o_tx_ready  <= (tx_state_nxt == TX_IDLE);
            if (tx_accept_c) begin
                sw.pkt_out <= {XW'(X), YW'(Y), i_tx_data};
            end
        end
    end

    // ---------------- RX path ----------------
    rx_state_e              rx_state;
    rx_state_e              rx_state_nxt;
    logic                   rx_pop_c;
    logic                   rx_wr_c;
    logic [PACKET_SIZE-1:0] rx_pkt;

    always_ff @(posedge clk) begin
        if (i_reset) rx_state <= RX_IDLE;
        else         rx_state <= rx_state_nxt;
    end

    always_comb begin
        rx_state_nxt = rx_state;
        rx_pop_c     = 1'b0;
        rx_wr_c      = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (sw.rd_valid && !o_vec_valid) begin
                    rx_pop_c     = 1'b1;
                    rx_state_nxt = RX_POP;
                end
            end
            RX_POP: begin
                rx_wr_c      = 1'b1;
                rx_state_nxt = RX_GAP;
            end
            RX_GAP:  rx_state_nxt = RX_IDLE;
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // Capture the fall-through word together with the pop strobe.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_pkt   <= '0;
            sw.rd_en <= 1'b0;
        end else begin
            sw.rd_en <= rx_pop_c;
            if (rx_pop_c) begin
                rx_pkt <= sw.pkt_in;
            end
        end
    end

    pe_vec_collect #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_collect (
        .clk           (clk),
        .i_reset       (i_reset),
        .i_wr          (rx_wr_c),
        .i_src         (rx_pkt[ADDR_LSB +: AW]),
        .i_payload     (rx_pkt[DW-1:0]),
        .i_expect_mask (i_expect_mask),
        .i_vec_ack     (i_vec_ack),
        .o_vec_valid   (o_vec_valid),
        .o_vec_data    (o_vec_data),
        .o_err_dup     (o_err_dup),
        .o_err_unexp   (o_err_unexp)
    );

`ifdef PE_NI_STATS_EN
    // Free-running packet counters, wrapping naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            o_tx_count <= 16'd0;
            o_rx_count <= 16'd0;
        end else begin
            if (sw.wr_valid) o_tx_count <= o_tx_count + 16'd1;
            if (sw.rd_en)    o_rx_count <= o_rx_count + 16'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pe_net_iface.sv
// Directed self-checking bench for pe_net_iface (node X=1, Y=2, 4x4 mesh).
// The switch PE output FIFO is modelled as a small array; entries are pushed
// by the stimulus and popped on every sampled rd_en.
module tb_pe_net_iface;

    logic         clk = 1'b0;
    logic         rst;
    logic         tx_valid;
    logic [11:0]  tx_data;
    logic         tx_ready;
    logic [15:0]  mask;
    logic         vec_valid;
    logic [191:0] vec_data;
    logic         ack;
    logic         err_dup;
    logic         err_unexp;
`ifdef PE_NI_STATS_EN
    logic [15:0]  tx_count;
    logic [15:0]  rx_count;
`endif

    int passed = 0;
    int total  = 0;

    logic [15:0] fifo [0:31];
    logic [4:0]  wp;
    logic [4:0]  rp;

    always #5 clk = ~clk;

    pe_net_iface_if #(.PACKET_SIZE(16)) sw_if ();

    assign sw_if.pkt_in   = fifo[rp];
    assign sw_if.rd_valid = (wp != rp);

    always @(posedge clk) begin
        if (rst)              rp <= wp;
        else if (sw_if.rd_en) rp <= rp + 5'd1;
    end

    pe_net_iface #(
        .PACKET_SIZE (16),
        .XNO         (4),
        .YNO         (4),
        .X           (1),
        .Y           (2)
    ) dut (
        .clk           (clk),
        .i_reset       (rst),
        .i_tx_valid    (tx_valid),
        .i_tx_data     (tx_data),
        .o_tx_ready    (tx_ready),
        .sw            (sw_if),
        .i_expect_mask (mask),
        .o_vec_valid   (vec_valid),
        .o_vec_data    (vec_data),
        .i_vec_ack     (ack),
        .o_err_dup     (err_dup),
`ifdef PE_NI_STATS_EN
        .o_err_unexp   (err_unexp),
        .o_tx_count    (tx_count),
        .o_rx_count    (rx_count)
`else
        .o_err_unexp   (err_unexp)
`endif
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] pkt);
        fifo[wp] = pkt;
        wp = wp + 5'd1;
    endtask

    task automatic wait_vec(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (vec_valid) break;
            tick();
        end
        check(tag, 256'(vec_valid), 256'(1));
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (wp == rp) break;
            tick();
        end
        check(tag, 256'(wp - rp), 256'(0));
        repeat (3) tick();
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    logic seen_strobe;

    initial begin
        rst = 1'b1; tx_valid = 1'b0; tx_data = 12'h0; mask = 16'h0; ack = 1'b0;
        sw_if.wr_ready = 1'b1; wp = 5'd0;
        tick(); tick();
        check("reset_tx", 256'({tx_ready, sw_if.wr_valid, sw_if.pkt_out}), 256'(0));
        check("reset_rx", 256'({sw_if.rd_en, vec_valid, err_dup, err_unexp}), 256'(0));
        check("reset_vec", 256'(vec_data), 256'(0));
        rst = 1'b0;
        tick();
        check("ready_idle", 256'(tx_ready), 256'(1));

        // TX: single packet, switch ready
        tx_data = 12'hABC; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("tx_pack", 256'({sw_if.pkt_out, sw_if.wr_valid, tx_ready}), 256'({16'h6ABC, 2'b00}));
        tick();
        check("tx_strobe", 256'(sw_if.wr_valid), 256'(1));
        tick();
        check("tx_strobe_end", 256'({sw_if.wr_valid, tx_ready}), 256'(2'b01));

        // TX: switch FIFO full for 5 cycles
        sw_if.wr_ready = 1'b0;
        tx_data = 12'h123; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("tx_hold", 256'({sw_if.wr_valid, tx_ready}), 256'(2'b00));
        end
        sw_if.wr_ready = 1'b1;
        tick();
        check("tx_bp_strobe", 256'({sw_if.wr_valid, sw_if.pkt_out}), 256'({1'b1, 16'h6123}));
        tick();
        check("tx_bp_end", 256'(sw_if.wr_valid), 256'(0));

        // RX: two-source vector, third packet held until ack
        mask = 16'h0003;
        push(16'h0005); push(16'h1007); push(16'h0009);
        wait_vec("vec1_wait");
        check("vec1_slots", 256'(vec_data[23:0]), 256'(24'h007005));
        repeat (6) tick();
        check("vec1_stall", 256'({vec_valid, sw_if.rd_en, 5'(wp - rp)}), 256'({2'b10, 5'd1}));
        do_ack();
        check("vec1_ack", 256'(vec_valid), 256'(0));
        wait_empty("vec2_pop");
        check("vec2_partial", 256'({vec_valid, err_dup, err_unexp, vec_data[23:0]}),
              256'({3'b000, 24'h007009}));
        push(16'h100A);
        wait_vec("vec2_wait");
        check("vec2_slots", 256'(vec_data[23:0]), 256'(24'h00A009));
        do_ack();

        // RX: unexpected source is dropped
        mask = 16'h0001;
        push(16'h5123);
        wait_empty("unexp_pop");
        check("unexp_flag", 256'({err_unexp, err_dup, vec_valid}), 256'(3'b100));
        check("unexp_drop", 256'(vec_data[71:60]), 256'(0));
        push(16'h0111);
        wait_vec("unexp_vec");
        check("unexp_slot0", 256'(vec_data[11:0]), 256'(12'h111));
        do_ack();

        // RX: duplicate source overwrites its slot
        mask = 16'h0003;
        push(16'h0AAA); push(16'h0BBB); push(16'h1CCC);
        wait_vec("dup_vec");
        check("dup_flag", 256'(err_dup), 256'(1));
        check("dup_slots", 256'(vec_data[23:0]), 256'(24'hCCCBBB));
        do_ack();

        // Reset while TX_SEND
        sw_if.wr_ready = 1'b0;
        tx_data = 12'h777; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_tx", 256'({tx_ready, sw_if.wr_valid, sw_if.pkt_out}), 256'(0));
        check("rst_flags", 256'({err_dup, err_unexp, vec_valid}), 256'(0));
        rst = 1'b0;
        sw_if.wr_ready = 1'b1;
        seen_strobe = 1'b0;
        repeat (4) begin
            tick();
            seen_strobe = seen_strobe | sw_if.wr_valid;
        end
        check("rst_tx_no_write", 256'(seen_strobe), 256'(0));

        // Reset while RX_POP
        mask = 16'h0001;
        push(16'h0321);
        for (int i = 0; i < 10; i++) begin
            if (sw_if.rd_en) break;
            tick();
        end
        check("rx_reach_pop", 256'(sw_if.rd_en), 256'(1));
        rst = 1'b1;
        tick();
        check("rst_rx", 256'({sw_if.rd_en, vec_valid, vec_data}), 256'(0));
        rst = 1'b0;
        repeat (6) tick();
        check("rst_rx_bitmap", 256'({vec_valid, vec_data}), 256'(0));

`ifdef PE_NI_STATS_EN
        check("stats_reset", 256'({tx_count, rx_count}), 256'(0));
        mask = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tx_data = 12'(i); tx_valid = 1'b1;
            tick();
            tx_valid = 1'b0;
            tick(); tick();
        end
        push(16'h0001); push(16'h1002);
        wait_empty("stats_pop");
        check("stats_counts", 256'({tx_count, rx_count}), 256'({16'd3, 16'd2}));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
